period_meter: RTL and testbench



---
 rtl/period_meter.sv | 150 +++++++++++++++
 tb/tb_period_meter.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/period_meter.sv
`timescale 1ns/1ps
// period_meter: measures rising-to-rising intervals of an asynchronous square
// wave in clk cycles. The input is synchronised by two flops, a third flop
// provides the previous value for rising-edge detection (3 clk latency).
//
// Output handshake: period_valid is a one-cycle strobe with no back-pressure.
// period is updated in the same cycle the strobe is high and holds its value
// until the next update; the consumer must capture it while the strobe is high.
//
// Optional feature macro: PERIOD_AVG_EN. When defined, four consecutive
// intervals are summed and the truncated average is reported once per four.
// state_dbg exposes the FSM state (0=IDLE, 1=MEAS, 2=TOUT) for checkers.
module period_meter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             timeout,
  output logic             locked,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MEAS = 2'd1,
    TOUT = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             s1;
  logic             s2;
  logic             s3;
  logic             rise;

`ifdef PERIOD_AVG_EN
  logic [CNT_W+1:0] acc;
  logic [CNT_W+1:0] acc_sum;
  logic [1:0]       smp;
`endif

  // Synchroniser chain plus one delayed copy for edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= sig_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise      = s2 & ~s3;
  assign state_dbg = state;

`ifdef PERIOD_AVG_EN
  // Running sum including the interval that ends on the current edge.
  always_comb begin
    acc_sum = acc + {2'b00, cnt};
  end
`endif

  // Measurement FSM: counts between edges, reports periods, detects timeout.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      timeout      <= 1'b0;
      locked       <= 1'b0;
`ifdef PERIOD_AVG_EN
      acc          <= '0;
      smp          <= '0;
`endif
    end else begin
      period_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          // First edge only arms the counter; no interval exists yet.
          if (rise) begin
            state <= MEAS;
            cnt   <= CNT_ONE;
`ifdef PERIOD_AVG_EN
            acc   <= '0;
            smp   <= '0;
`endif
          end
        end
        MEAS: begin
          // Edge takes priority over saturation so a max-length interval
          // is still reported rather than timing out.
          if (rise) begin
            cnt <= CNT_ONE;
`ifdef PERIOD_AVG_EN
            if (smp == 2'd3) begin
              period       <= CNT_W'(acc_sum >> 2);
              period_valid <= 1'b1;
              locked       <= 1'b1;
              acc          <= '0;
              smp          <= '0;
            end else begin
              acc <= acc_sum;
              smp <= smp + 2'd1;
            end
`else
            period       <= cnt;
            period_valid <= 1'b1;
            locked       <= 1'b1;
`endif
          end else if (cnt == CNT_MAX) begin
            state   <= TOUT;
            timeout <= 1'b1;
            locked  <= 1'b0;
`ifdef PERIOD_AVG_EN
            acc     <= '0;
            smp     <= '0;
`endif
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        TOUT: begin
          // Counter stays frozen; the next edge re-arms without a strobe.
          if (rise) begin
            state   <= MEAS;
            cnt     <= CNT_ONE;
            timeout <= 1'b0;
`ifdef PERIOD_AVG_EN
            acc     <= '0;
            smp     <= '0;
`endif
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_period_meter.sv
`timescale 1ns/1ps
// Directed bench for period_meter, built with CNT_W=8 so the timeout is short.
module tb_period_meter;

  localparam int CNT_W = 8;

  logic             clk;
  logic             reset;
  logic             sig_in;
  logic [CNT_W-1:0] period;
  logic             period_valid;
  logic             timeout;
  logic             locked;
  logic [1:0]       state_dbg;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int tout_cnt = 0;

  logic [CNT_W-1:0] obs_q[$];
  int               obs_t[$];
  logic [CNT_W-1:0] exp_q[$];

  period_meter #(.CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .sig_in       (sig_in),
    .period       (period),
    .period_valid (period_valid),
    .timeout      (timeout),
    .locked       (locked),
    .state_dbg    (state_dbg)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Strobe monitor: stamps every reported period with its cycle number.
  always @(posedge clk) begin
    #1;
    cyc = cyc + 1;
    if (period_valid) begin
      obs_q.push_back(period);
      obs_t.push_back(cyc);
    end
    if (timeout) tout_cnt = tout_cnt + 1;
  end

  // Driver tasks
  task automatic wave(input int hi, input int lo);
    sig_in = 1'b1;
    repeat (hi) @(negedge clk);
    sig_in = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic do_reset();
    sig_in = 1'b0;
    reset  = 1'b1;
    @(negedge clk);
    reset  = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    sig_in = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (period !== '0) begin n_fail++; $display("FAIL rst_period: got %0d expected 0", period); end
    n_checks++;
    if (period_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b expected 0", period_valid); end
    n_checks++;
    if (timeout !== 1'b0) begin n_fail++; $display("FAIL rst_timeout: got %b expected 0", timeout); end
    n_checks++;
    if (locked !== 1'b0) begin n_fail++; $display("FAIL rst_locked: got %b expected 0", locked); end
    n_checks++;
    if (state_dbg !== 2'd0) begin n_fail++; $display("FAIL rst_state: got %0d expected 0", state_dbg); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int base;
    do_reset();
    base = obs_q.size();
    wave(4, 4);
    n_checks++;
    if (obs_q.size() !== base) begin n_fail++; $display("FAIL basic_arm: got %0d strobes expected 0", obs_q.size() - base); end
    n_checks++;
    if (locked !== 1'b0) begin n_fail++; $display("FAIL basic_arm_locked: got %b expected 0", locked); end
    repeat (3) wave(4, 4);
    exp_q = '{8'd8, 8'd8, 8'd8};
    n_checks++;
    if (obs_q.size() - base !== exp_q.size()) begin n_fail++; $display("FAIL basic_count: got %0d expected %0d", obs_q.size() - base, exp_q.size()); end
    for (int i = 0; i < exp_q.size() && base + i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[base+i] !== exp_q[i]) begin n_fail++; $display("FAIL basic_period[%0d]: got %0d expected %0d", i, obs_q[base+i], exp_q[i]); end
    end
    for (int i = 1; i < 3 && base + i < obs_t.size(); i++) begin
      n_checks++;
      if (obs_t[base+i] - obs_t[base+i-1] !== 8) begin n_fail++; $display("FAIL basic_spacing[%0d]: got %0d expected 8", i, obs_t[base+i] - obs_t[base+i-1]); end
    end
    n_checks++;
    if (locked !== 1'b1) begin n_fail++; $display("FAIL basic_locked: got %b expected 1", locked); end
    n_checks++;
    if (period !== 8'd8) begin n_fail++; $display("FAIL basic_held: got %0d expected 8", period); end
  endtask

  task automatic test_step();
    int base;
    do_reset();
    base = obs_q.size();
    repeat (3) wave(5, 5);
    repeat (4) wave(3, 3);
    repeat (4) @(negedge clk);
    exp_q = '{8'd10, 8'd10, 8'd10, 8'd6, 8'd6, 8'd6};
    n_checks++;
    if (obs_q.size() - base !== exp_q.size()) begin n_fail++; $display("FAIL step_count: got %0d expected %0d", obs_q.size() - base, exp_q.size()); end
    for (int i = 0; i < exp_q.size() && base + i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[base+i] !== exp_q[i]) begin n_fail++; $display("FAIL step_period[%0d]: got %0d expected %0d", i, obs_q[base+i], exp_q[i]); end
    end
  endtask

  task automatic test_timeout();
    int base;
    int t_tout;
    bit seen;
    do_reset();
    repeat (3) wave(4, 4);
    base = obs_q.size();
    seen = 1'b0;
    t_tout = 0;
    for (int k = 0; k < 400 && !seen; k++) begin
      @(negedge clk);
      if (timeout === 1'b1) begin seen = 1'b1; t_tout = cyc; end
    end
    n_checks++;
    if (!seen) begin
      n_fail++; $display("FAIL tout_seen: got 0 expected 1 within 400 cycles");
    end else begin
      n_checks++;
      if (obs_t.size() == 0 || t_tout - obs_t[obs_t.size()-1] !== 255) begin
        n_fail++; $display("FAIL tout_delay: got %0d expected 255", (obs_t.size() == 0) ? -1 : t_tout - obs_t[obs_t.size()-1]);
      end
    end
    n_checks++;
    if (locked !== 1'b0) begin n_fail++; $display("FAIL tout_locked: got %b expected 0", locked); end
    n_checks++;
    if (period !== 8'd8) begin n_fail++; $display("FAIL tout_period_held: got %0d expected 8", period); end
    n_checks++;
    if (state_dbg !== 2'd2) begin n_fail++; $display("FAIL tout_state: got %0d expected 2", state_dbg); end
    wave(4, 4);
    n_checks++;
    if (timeout !== 1'b0) begin n_fail++; $display("FAIL tout_clear: got %b expected 0", timeout); end
    n_checks++;
    if (obs_q.size() !== base) begin n_fail++; $display("FAIL tout_no_strobe: got %0d strobes expected 0", obs_q.size() - base); end
    n_checks++;
    if (locked !== 1'b0) begin n_fail++; $display("FAIL tout_rearm_locked: got %b expected 0", locked); end
    wave(4, 4);
    n_checks++;
    if (obs_q.size() - base !== 1) begin
      n_fail++; $display("FAIL tout_relock_count: got %0d expected 1", obs_q.size() - base);
    end else begin
      n_checks++;
      if (obs_q[base] !== 8'd8) begin n_fail++; $display("FAIL tout_relock_period: got %0d expected 8", obs_q[base]); end
    end
    n_checks++;
    if (locked !== 1'b1) begin n_fail++; $display("FAIL tout_relock_locked: got %b expected 1", locked); end
  endtask

  task automatic test_limits();
    int base;
    int tbase;
    do_reset();
    base = obs_q.size();
    repeat (6) wave(1, 1);
    repeat (4) @(negedge clk);
    exp_q = '{8'd2, 8'd2, 8'd2, 8'd2, 8'd2};
    n_checks++;
    if (obs_q.size() - base !== exp_q.size()) begin n_fail++; $display("FAIL min_count: got %0d expected %0d", obs_q.size() - base, exp_q.size()); end
    for (int i = 0; i < exp_q.size() && base + i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[base+i] !== exp_q[i]) begin n_fail++; $display("FAIL min_period[%0d]: got %0d expected %0d", i, obs_q[base+i], exp_q[i]); end
      if (i > 0) begin
        n_checks++;
        if (obs_t[base+i] - obs_t[base+i-1] !== 2) begin n_fail++; $display("FAIL min_spacing[%0d]: got %0d expected 2", i, obs_t[base+i] - obs_t[base+i-1]); end
      end
    end
    do_reset();
    base  = obs_q.size();
    tbase = tout_cnt;
    wave(1, 254);
    wave(1, 5);
    repeat (4) @(negedge clk);
    n_checks++;
    if (obs_q.size() - base !== 1) begin
      n_fail++; $display("FAIL max_count: got %0d expected 1", obs_q.size() - base);
    end else begin
      n_checks++;
      if (obs_q[base] !== 8'd255) begin n_fail++; $display("FAIL max_period: got %0d expected 255", obs_q[base]); end
    end
    n_checks++;
    if (tout_cnt !== tbase) begin n_fail++; $display("FAIL max_no_timeout: got %0d timeout cycles expected 0", tout_cnt - tbase); end
    n_checks++;
    if (locked !== 1'b1) begin n_fail++; $display("FAIL max_locked: got %b expected 1", locked); end
  endtask

  task automatic test_mid_reset();
    int base;
    do_reset();
    repeat (2) wave(4, 4);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({period, period_valid, timeout, locked} !== '0) begin
      n_fail++; $display("FAIL mid_reset_outputs: got p=%0d v=%b t=%b l=%b expected all 0", period, period_valid, timeout, locked);
    end
    n_checks++;
    if (state_dbg !== 2'd0) begin n_fail++; $display("FAIL mid_reset_state: got %0d expected 0", state_dbg); end
    reset = 1'b0;
    @(negedge clk);
    base = obs_q.size();
    wave(5, 5);
    n_checks++;
    if (obs_q.size() !== base) begin n_fail++; $display("FAIL mid_reset_arm: got %0d strobes expected 0", obs_q.size() - base); end
    repeat (2) wave(5, 5);
    repeat (4) @(negedge clk);
    exp_q = '{8'd10, 8'd10};
    n_checks++;
    if (obs_q.size() - base !== exp_q.size()) begin n_fail++; $display("FAIL mid_reset_count: got %0d expected %0d", obs_q.size() - base, exp_q.size()); end
    for (int i = 0; i < exp_q.size() && base + i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[base+i] !== exp_q[i]) begin n_fail++; $display("FAIL mid_reset_period[%0d]: got %0d expected %0d", i, obs_q[base+i], exp_q[i]); end
    end
  endtask

  task automatic test_avg();
    int base;
    do_reset();
    base = obs_q.size();
    wave(4, 4);
    wave(4, 4);
    wave(4, 5);
    wave(4, 5);
    n_checks++;
    if (obs_q.size() !== base) begin n_fail++; $display("FAIL avg_early: got %0d strobes expected 0", obs_q.size() - base); end
    n_checks++;
    if (locked !== 1'b0) begin n_fail++; $display("FAIL avg_early_locked: got %b expected 0", locked); end
    wave(2, 3);
    wave(3, 3);
    wave(3, 4);
    wave(4, 4);
    wave(1, 3);
    repeat (4) @(negedge clk);
    exp_q = '{8'd8, 8'd6};
    n_checks++;
    if (obs_q.size() - base !== exp_q.size()) begin n_fail++; $display("FAIL avg_count: got %0d expected %0d", obs_q.size() - base, exp_q.size()); end
    for (int i = 0; i < exp_q.size() && base + i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[base+i] !== exp_q[i]) begin n_fail++; $display("FAIL avg_period[%0d]: got %0d expected %0d", i, obs_q[base+i], exp_q[i]); end
    end
    n_checks++;
    if (locked !== 1'b1) begin n_fail++; $display("FAIL avg_locked: got %b expected 1", locked); end
  endtask

  // Test sequence and final report
  initial begin
    reset  = 1'b1;
    sig_in = 1'b0;
    test_reset();
`ifdef PERIOD_AVG_EN
    test_avg();
`else
    test_basic();
    test_step();
    test_timeout();
    test_limits();
    test_mid_reset();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
